// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, LU results queued.
// Optional same-cycle LU bypass when WB_ARB_BYPASS_EN is defined.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_rd_i,
    input  logic [31:0] lu_data_i,
    output logic        lu_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_data_o,
    output logic        stall_o,
    input  logic [4:0]  hz_rs1_i,
    input  logic [4:0]  hz_rs2_i,
    input  logic [4:0]  hz_rd_i,
    output logic        hz_pend_o,
    output logic        pend_busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

`ifdef WB_ARB_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   wp_q, wp_d;
    logic [AW:0]   rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    rd_mem_q   [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];

    logic        empty, full;
    logic        pipe_live, xfer;
    logic        push, pop, byp;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic [AW:0] occ;
    logic        hit;

    assign empty     = (wp_q == rp_q);
    assign full      = (wp_q[AW] != rp_q[AW]) &&
                       (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign head_rd   = rd_mem_q[rp_q[AW-1:0]];
    assign head_data = data_mem_q[rp_q[AW-1:0]];
    assign pipe_live = pipe_we_i && (pipe_rd_i != 5'd0);
    assign lu_ready_o = !full && !rst_i;
    assign xfer      = lu_valid_i && lu_ready_o;
    assign occ       = wp_q - rp_q;

    always_comb begin
        rf_we_o   = 1'b0;
        rf_rd_o   = 5'd0;
        rf_data_o = 32'd0;
        stall_o   = 1'b0;
        pop       = 1'b0;
        byp       = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                ST_FORCE: begin
                    stall_o = 1'b1;
                    if (!empty) begin
                        rf_we_o   = 1'b1;
                        rf_rd_o   = head_rd;
                        rf_data_o = head_data;
                        pop       = 1'b1;
                    end
                end
                default: begin
                    if (pipe_live) begin
                        rf_we_o   = 1'b1;
                        rf_rd_o   = pipe_rd_i;
                        rf_data_o = pipe_data_i;
                    end else if (!empty) begin
                        rf_we_o   = 1'b1;
                        rf_rd_o   = head_rd;
                        rf_data_o = head_data;
                        pop       = 1'b1;
                    end else if (BypassEn && xfer && lu_rd_i != 5'd0) begin
                        rf_we_o   = 1'b1;
                        rf_rd_o   = lu_rd_i;
                        rf_data_o = lu_data_i;
                        byp       = 1'b1;
                    end
                end
            endcase
        end
    end

    // rd==0 results are swallowed here; bypassed results skip the queue
    assign push = xfer && (lu_rd_i != 5'd0) && !byp;
    assign wp_d = wp_q + (AW+1)'(push);
    assign rp_d = rp_q + (AW+1)'(pop);

    always_comb begin
        cnt_d   = '0;
        state_d = ST_NORMAL;
        if (state_q == ST_NORMAL && !empty && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (cnt_d == CW'(STARVE_LIMIT)) begin
            state_d = ST_FORCE;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [AW-1:0] idx;
            logic [4:0]    erd;
            idx = rp_q[AW-1:0] + AW'(i);
            erd = rd_mem_q[idx];
            if ((AW+1)'(i) < occ) begin
                if ((hz_rs1_i != 5'd0 && erd == hz_rs1_i) ||
                    (hz_rs2_i != 5'd0 && erd == hz_rs2_i) ||
                    (hz_rd_i  != 5'd0 && erd == hz_rd_i)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign hz_pend_o   = hit && !rst_i;
    assign pend_busy_o = !empty && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_NORMAL;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_mem_q[wp_q[AW-1:0]]   <= lu_rd_i;
            data_mem_q[wp_q[AW-1:0]] <= lu_data_i;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=8).
module tb_wb_port_arbiter;

`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_rd_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        lu_valid_i = 1'b0;
    logic [4:0]  lu_rd_i = '0;
    logic [31:0] lu_data_i = '0;
    logic        lu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;
    logic        stall_o;
    logic [4:0]  hz_rs1_i = '0;
    logic [4:0]  hz_rs2_i = '0;
    logic [4:0]  hz_rd_i = '0;
    logic        hz_pend_o;
    logic        pend_busy_o;

    wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i),
        .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i),
        .lu_data_i(lu_data_i), .lu_ready_o(lu_ready_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o),
        .rf_data_o(rf_data_o), .stall_o(stall_o),
        .hz_rs1_i(hz_rs1_i), .hz_rs2_i(hz_rs2_i),
        .hz_rd_i(hz_rd_i), .hz_pend_o(hz_pend_o),
        .pend_busy_o(pend_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        logic        st;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rf_we_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected got rd=%0d data=%h cyc=%0d want no write",
                         rf_rd_o, rf_data_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (rf_rd_o !== e.rd || rf_data_o !== e.d ||
                    stall_o !== e.st || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL wb_write got rd=%0d data=%h stall=%b cyc=%0d want rd=%0d data=%h stall=%b cyc=%0d",
                             rf_rd_o, rf_data_o, stall_o, cyc, e.rd, e.d, e.st, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_w(input logic [4:0] rd, input logic [31:0] d,
                            input logic st, input int c);
        exp_t e;
        e.rd = rd; e.d = d; e.st = st; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {22'd0, rf_we_o, rf_rd_o, rf_data_o, lu_ready_o,
                stall_o, hz_pend_o, pend_busy_o};
    endfunction

    initial begin
        // reset
        step();
        chk("rst_outputs", all_out(), 64'd0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_busy", {63'd0, pend_busy_o}, 64'd0);
        chk("post_rst_ready", {63'd0, lu_ready_o}, 64'd1);

        // idle pipeline, single LU result
        lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_data_i = 32'hDEADBEEF;
        #1 chk("t1_ready", {63'd0, lu_ready_o}, 64'd1);
        expect_w(5'd5, 32'hDEADBEEF, 1'b0, BYP ? cyc : cyc + 1);
        step();
        lu_valid_i = 1'b0;
        chk("t1_busy", {63'd0, pend_busy_o}, BYP ? 64'd0 : 64'd1);
        step();
        chk("t1_drained", {63'd0, pend_busy_o}, 64'd0);

        // starvation: forced drain on the 9th head cycle
        pipe_we_i = 1'b1; pipe_rd_i = 5'd3;
        for (int k = 0; k < 11; k++) begin
            if (k < 10) pipe_data_i = 32'h300 + k;
            lu_valid_i = (k == 0); lu_rd_i = 5'd7; lu_data_i = 32'h11;
            if (k == 9) expect_w(5'd7, 32'h11, 1'b1, cyc);
            else expect_w(5'd3, pipe_data_i, 1'b0, cyc);
            step();
        end
        pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        chk("t2_busy", {63'd0, pend_busy_o}, 64'd0);
        step();

        // full FIFO backpressure and drain order
        pipe_we_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h400;
        lu_valid_i = 1'b1; lu_rd_i = 5'd10; lu_data_i = 32'hA;
        expect_w(5'd3, 32'h400, 1'b0, cyc);
        step();
        pipe_data_i = 32'h401; lu_rd_i = 5'd11; lu_data_i = 32'hB;
        expect_w(5'd3, 32'h401, 1'b0, cyc);
        step();
        pipe_data_i = 32'h402; lu_rd_i = 5'd12; lu_data_i = 32'hC;
        #1 chk("t3_full_ready", {63'd0, lu_ready_o}, 64'd0);
        expect_w(5'd3, 32'h402, 1'b0, cyc);
        step();
        pipe_we_i = 1'b0;
        #1 chk("t3_pop_noref", {63'd0, lu_ready_o}, 64'd0);
        expect_w(5'd10, 32'hA, 1'b0, cyc);
        step();
        chk("t3_ready_again", {63'd0, lu_ready_o}, 64'd1);
        expect_w(5'd11, 32'hB, 1'b0, cyc);
        step();
        lu_valid_i = 1'b0;
        expect_w(5'd12, 32'hC, 1'b0, cyc);
        step();
        chk("t3_empty", {63'd0, pend_busy_o}, 64'd0);

        // hazard query
        pipe_we_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h500;
        lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_data_i = 32'h99;
        expect_w(5'd3, 32'h500, 1'b0, cyc);
        step();
        lu_valid_i = 1'b0; pipe_data_i = 32'h501;
        expect_w(5'd3, 32'h501, 1'b0, cyc);
        hz_rs2_i = 5'd9;
        #1 chk("t4_rs2_hit", {63'd0, hz_pend_o}, 64'd1);
        hz_rs2_i = 5'd0; hz_rs1_i = 5'd0;
        #1 chk("t4_zero_q", {63'd0, hz_pend_o}, 64'd0);
        hz_rd_i = 5'd9;
        #1 chk("t4_rd_hit", {63'd0, hz_pend_o}, 64'd1);
        hz_rd_i = 5'd0;
        step();
        pipe_we_i = 1'b0; hz_rs2_i = 5'd9;
        expect_w(5'd9, 32'h99, 1'b0, cyc);
        #1 chk("t4_pop_cycle", {63'd0, hz_pend_o}, 64'd1);
        step();
        chk("t4_after_pop", {63'd0, hz_pend_o}, 64'd0);
        hz_rs2_i = 5'd0;

        // rd==0 LU result and rd==0 pipeline write
        lu_valid_i = 1'b1; lu_rd_i = 5'd0; lu_data_i = 32'h55;
        #1 chk("t5_rd0_ready", {63'd0, lu_ready_o}, 64'd1);
        step();
        chk("t5_rd0_busy", {63'd0, pend_busy_o}, 64'd0);
        chk("t5_rd0_nowe", {63'd0, rf_we_o}, 64'd0);
        pipe_we_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h600;
        lu_rd_i = 5'd14; lu_data_i = 32'hE;
        expect_w(5'd3, 32'h600, 1'b0, cyc);
        step();
        lu_valid_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = 32'h601;
        expect_w(5'd14, 32'hE, 1'b0, cyc);
        step();
        pipe_we_i = 1'b0;
        chk("t5_busy", {63'd0, pend_busy_o}, 64'd0);

        // reset while in FORCE with two queued entries
        pipe_we_i = 1'b1; pipe_rd_i = 5'd3;
        for (int k = 0; k < 9; k++) begin
            pipe_data_i = 32'h700 + k;
            lu_valid_i = (k < 2);
            lu_rd_i = 5'd20 + 5'(k); lu_data_i = 32'h2000 + k;
            expect_w(5'd3, pipe_data_i, 1'b0, cyc);
            step();
        end
        lu_valid_i = 1'b0;
        chk("t6_force", {63'd0, stall_o}, 64'd1);
        rst_i = 1'b1;
        #1 chk("t6_rst_out", all_out(), 64'd0);
        step();
        chk("t6_next_out", all_out(), 64'd0);
        rst_i = 1'b0; pipe_we_i = 1'b0;
        #1 chk("t6_busy", {63'd0, pend_busy_o}, 64'd0);
        chk("t6_stall", {63'd0, stall_o}, 64'd0);
        repeat (12) step();

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
